led_shift_driver: RTL



---
 rtl/led_shift_driver_if.sv | 22 ++
 rtl/led_shift_driver.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/led_shift_driver_if.sv
// Bundle between the LED PIO and the shift-register driver: the pattern going in
// and the three serial pins plus the status flags coming out.
interface led_shift_driver_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pattern_in;
  logic             ser_data;
  logic             ser_clk;
  logic             ser_latch;
  logic             busy;
  logic             frame_done;

  modport master (
    output pattern_in,
    input  ser_data, ser_clk, ser_latch, busy, frame_done
  );

  modport slave (
    input  pattern_in,
    output ser_data, ser_clk, ser_latch, busy, frame_done
  );
endinterface

// File: rtl/led_shift_driver.sv
// Serialises the LED pattern into a 74HC595-style chain (data, shift clock, latch),
// refreshing after reset and whenever the pattern differs from the last one sent.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | outputs quiet; start a frame on init_pending or pattern change
// S_SETUP | ser_clk low, current MSB presented on ser_data
// S_HIGH  | ser_clk high, chain samples ser_data; then shift or finish
// S_LATCH | ser_latch high to transfer the chain into its storage register
module led_shift_driver #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  led_shift_driver_if.slave bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LATCH
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic               init_pending_q, init_pending_d;
  logic               ser_data_q, ser_data_d;
  logic               ser_clk_q, ser_clk_d;
  logic               ser_latch_q, ser_latch_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               phase_end;

  assign phase_end = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d        = state_q;
    div_cnt_d      = div_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    shadow_d       = shadow_q;
    init_pending_d = init_pending_q;
    frame_done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        if (init_pending_q || (bus.pattern_in != shadow_q)) begin
          shreg_d        = bus.pattern_in;
          shadow_d       = bus.pattern_in;
          init_pending_d = 1'b0;
          bit_cnt_d      = BIT_LAST;
          state_d        = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          div_cnt_d = '0;
          state_d   = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == '0) begin
            state_d = S_LATCH;
          end else begin
            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 1'b1;
            state_d   = S_SETUP;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (phase_end) begin
          div_cnt_d    = '0;
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        div_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    // Pins are decoded from the next state so they change on the same edge as the state.
    busy_d      = (state_d != S_IDLE);
    ser_clk_d   = (state_d == S_HIGH);
    ser_latch_d = (state_d == S_LATCH);
    ser_data_d  = ((state_d == S_SETUP) || (state_d == S_HIGH)) ? shreg_d[WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      div_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      shadow_q       <= '0;
      init_pending_q <= 1'b1;
      ser_data_q     <= 1'b0;
      ser_clk_q      <= 1'b0;
      ser_latch_q    <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      shadow_q       <= shadow_d;
      init_pending_q <= init_pending_d;
      ser_data_q     <= ser_data_d;
      ser_clk_q      <= ser_clk_d;
      ser_latch_q    <= ser_latch_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign bus.ser_data   = ser_data_q;
  assign bus.ser_clk    = ser_clk_q;
  assign bus.ser_latch  = ser_latch_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule
